// File: rtl/arbitro_memoria_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter.
package arbitro_memoria_pkg;

  // Arbiter state encoding; 2'd3 is unused and recovers to OCIOSO.
  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  // Default memory latency in cycles (legal range 1..15).
  localparam int LAT_MEM_PADRAO = 2;

  // Width of the ACESSO down-counter.
  localparam int LARG_CONT = 4;

  // Counter load value: the counter runs LAT_MEM-1 down to 0, one step per ACESSO cycle.
  function automatic logic [LARG_CONT-1:0] carga_contador(input int lat);
    return LARG_CONT'(lat - 1);
  endfunction

endpackage

// File: rtl/arbitro_memoria.sv
// Two-requester (fetch / data) arbiter for a single shared memory port.
// Fixed-latency accesses: OCIOSO -> ACESSO (LAT_MEM cycles) -> RESPOSTA (1 cycle).
module arbitro_memoria
  import arbitro_memoria_pkg::*;
#(
  parameter int LARG_END  = 8,
  parameter int LARG_DADO = 16,
  parameter int LAT_MEM   = LAT_MEM_PADRAO
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // Instruction fetch requester (read only)
  input  logic                 req_if,
  input  logic [LARG_END-1:0]  end_if,
  // Data requester
  input  logic                 req_dados,
  input  logic                 esc_dados,
  input  logic [LARG_END-1:0]  end_dados,
  input  logic [LARG_DADO-1:0] dado_esc,
  // Grants, completion pulses and read data
  output logic                 gnt_if,
  output logic                 gnt_dados,
  output logic                 pronto_if,
  output logic                 pronto_dados,
  output logic [LARG_DADO-1:0] dado_lido,
  output logic                 ocupado,
  // Shared memory port
  output logic                 mem_en,
  output logic                 mem_esc,
  output logic [LARG_END-1:0]  mem_end,
  output logic [LARG_DADO-1:0] mem_dado_esc,
  input  logic [LARG_DADO-1:0] mem_dado_lido
);

  localparam logic [LARG_CONT-1:0] CONT_INI = carga_contador(LAT_MEM);

  estado_t                estado_q;
  logic [LARG_CONT-1:0]   cont_q;
  logic                   ult_dados_q;   // 1 = data was the last requester served
  logic                   venc_dados_q;  // 1 = data owns the current access
  logic                   esc_q;         // current access is a data write
  logic [LARG_END-1:0]    end_q;
  logic [LARG_DADO-1:0]   dado_esc_q;
  logic [LARG_DADO-1:0]   dado_lido_q;
  logic                   gnt_if_q;
  logic                   gnt_dados_q;
  logic                   pronto_if_q;
  logic                   pronto_dados_q;
  logic                   mem_en_q;
  logic                   mem_esc_q;
  logic                   ocupado_q;
  logic                   escolhe_dados_d;

  // Winner selection: a lone request wins; on contention the side not served last wins.
  always_comb begin
    escolhe_dados_d = req_dados & (~req_if | ~ult_dados_q);
  end

  // Arbiter FSM with latched port registers and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q       <= OCIOSO;
      cont_q         <= '0;
      ult_dados_q    <= 1'b0;
      venc_dados_q   <= 1'b0;
      esc_q          <= 1'b0;
      end_q          <= '0;
      dado_esc_q     <= '0;
      dado_lido_q    <= '0;
      gnt_if_q       <= 1'b0;
      gnt_dados_q    <= 1'b0;
      pronto_if_q    <= 1'b0;
      pronto_dados_q <= 1'b0;
      mem_en_q       <= 1'b0;
      mem_esc_q      <= 1'b0;
      ocupado_q      <= 1'b0;
    end else begin
      // Pulses last one cycle unless re-asserted below.
      pronto_if_q    <= 1'b0;
      pronto_dados_q <= 1'b0;
      mem_esc_q      <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (req_if || req_dados) begin
            estado_q     <= ACESSO;
            cont_q       <= CONT_INI;
            venc_dados_q <= escolhe_dados_d;
            esc_q        <= escolhe_dados_d & esc_dados;
            end_q        <= escolhe_dados_d ? end_dados : end_if;
            if (escolhe_dados_d) begin
              dado_esc_q <= dado_esc;
            end
            gnt_if_q     <= ~escolhe_dados_d;
            gnt_dados_q  <= escolhe_dados_d;
            mem_en_q     <= 1'b1;
            mem_esc_q    <= escolhe_dados_d & esc_dados;
            ocupado_q    <= 1'b1;
          end
        end
        ACESSO: begin
          if (cont_q == '0) begin
            estado_q       <= RESPOSTA;
            mem_en_q       <= 1'b0;
            pronto_if_q    <= ~venc_dados_q;
            pronto_dados_q <= venc_dados_q;
            if (!esc_q) begin
              dado_lido_q  <= mem_dado_lido;
            end
          end else begin
            cont_q <= cont_q - 1'b1;
          end
        end
        RESPOSTA: begin
          estado_q    <= OCIOSO;
          ult_dados_q <= venc_dados_q;
          gnt_if_q    <= 1'b0;
          gnt_dados_q <= 1'b0;
          ocupado_q   <= 1'b0;
        end
        default: begin
          estado_q    <= OCIOSO;
          gnt_if_q    <= 1'b0;
          gnt_dados_q <= 1'b0;
          mem_en_q    <= 1'b0;
          ocupado_q   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_if       = gnt_if_q;
  assign gnt_dados    = gnt_dados_q;
  assign pronto_if    = pronto_if_q;
  assign pronto_dados = pronto_dados_q;
  assign dado_lido    = dado_lido_q;
  assign ocupado      = ocupado_q;
  assign mem_en       = mem_en_q;
  assign mem_esc      = mem_esc_q;
  assign mem_end      = end_q;
  assign mem_dado_esc = dado_esc_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Self-checking bench for arbitro_memoria: directed scenarios, randomized traffic
// against a transaction-level reference, and latency checks at LAT_MEM = 1 and 15.
module tb_arbitro_memoria;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;

  // Main instance (LAT_MEM = 2)
  logic        req_if, req_dados, esc_dados;
  logic [7:0]  end_if, end_dados;
  logic [15:0] dado_esc;
  logic        gnt_if, gnt_dados, pronto_if, pronto_dados, ocupado;
  logic [15:0] dado_lido;
  logic        mem_en, mem_esc;
  logic [7:0]  mem_end;
  logic [15:0] mem_dado_esc, mem_dado_lido;

  // Latency instances (LAT_MEM = 1 -> a_*, LAT_MEM = 15 -> b_*), fetch only
  logic        a_req, b_req;
  logic [7:0]  a_end, b_end;
  logic        a_gnt_if, a_gnt_d, a_pronto, a_pronto_d, a_ocupado, a_mem_en, a_mem_esc;
  logic        b_gnt_if, b_gnt_d, b_pronto, b_pronto_d, b_ocupado, b_mem_en, b_mem_esc;
  logic [15:0] a_lido, b_lido, a_mem_de, b_mem_de;
  logic [7:0]  a_mem_end, b_mem_end;

  // Memory behind the main instance, plus its seed contents
  logic [15:0] mem_bench [256];
  logic [15:0] semente   [256];
  logic        carga;

  // Reference model state
  logic [15:0] ref_mem [256];
  logic [15:0] exp_lido;
  bit          ult_dados;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  arbitro_memoria #(.LARG_END(8), .LARG_DADO(16), .LAT_MEM(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_if(req_if), .end_if(end_if),
    .req_dados(req_dados), .esc_dados(esc_dados), .end_dados(end_dados), .dado_esc(dado_esc),
    .gnt_if(gnt_if), .gnt_dados(gnt_dados), .pronto_if(pronto_if), .pronto_dados(pronto_dados),
    .dado_lido(dado_lido), .ocupado(ocupado),
    .mem_en(mem_en), .mem_esc(mem_esc), .mem_end(mem_end), .mem_dado_esc(mem_dado_esc),
    .mem_dado_lido(mem_dado_lido)
  );

  arbitro_memoria #(.LARG_END(8), .LARG_DADO(16), .LAT_MEM(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req_if(a_req), .end_if(a_end),
    .req_dados(1'b0), .esc_dados(1'b0), .end_dados(8'h00), .dado_esc(16'h0000),
    .gnt_if(a_gnt_if), .gnt_dados(a_gnt_d), .pronto_if(a_pronto), .pronto_dados(a_pronto_d),
    .dado_lido(a_lido), .ocupado(a_ocupado),
    .mem_en(a_mem_en), .mem_esc(a_mem_esc), .mem_end(a_mem_end), .mem_dado_esc(a_mem_de),
    .mem_dado_lido({8'h5A, a_mem_end})
  );

  arbitro_memoria #(.LARG_END(8), .LARG_DADO(16), .LAT_MEM(15)) u_lat15 (
    .clk(clk), .rst_n(rst_n),
    .req_if(b_req), .end_if(b_end),
    .req_dados(1'b0), .esc_dados(1'b0), .end_dados(8'h00), .dado_esc(16'h0000),
    .gnt_if(b_gnt_if), .gnt_dados(b_gnt_d), .pronto_if(b_pronto), .pronto_dados(b_pronto_d),
    .dado_lido(b_lido), .ocupado(b_ocupado),
    .mem_en(b_mem_en), .mem_esc(b_mem_esc), .mem_end(b_mem_end), .mem_dado_esc(b_mem_de),
    .mem_dado_lido({8'h5A, b_mem_end})
  );

  // Behavioural memory: combinational read, write on the edge ending a write cycle.
  assign mem_dado_lido = mem_bench[mem_end];

  always @(posedge clk) begin
    if (carga) begin
      for (int i = 0; i < 256; i++) mem_bench[i] <= semente[i];
    end else if (mem_en && mem_esc) begin
      mem_bench[mem_end] <= mem_dado_esc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ocupado"}, ocupado, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_esc"}, mem_esc, 0);
    check({tag, "_gnt"}, {gnt_if, gnt_dados}, 0);
    check({tag, "_pronto"}, {pronto_if, pronto_dados}, 0);
    check({tag, "_dado_lido"}, dado_lido, exp_lido);
  endtask

  // One access on the main instance. Called at a falling edge with the arbiter idle
  // and the request inputs already set; returns at a falling edge with it idle again.
  task automatic txn(input bit muda, input logic [7:0] novo_end);
    bit          win_d;
    bit          ew;
    logic [7:0]  ea;
    logic [15:0] ed;
    if (req_if && req_dados) win_d = !ult_dados;
    else                     win_d = req_dados;
    ea = win_d ? end_dados : end_if;
    ew = win_d && esc_dados;
    ed = dado_esc;
    if (ew) ref_mem[ea] = ed;
    else    exp_lido    = ref_mem[ea];
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      check("ocupado", ocupado, 1);
      check("gnt_if", gnt_if, !win_d);
      check("gnt_dados", gnt_dados, win_d);
      check("mem_en", mem_en, k <= LAT);
      check("mem_esc", mem_esc, ew && k == 1);
      check("mem_end", mem_end, ea);
      if (ew && k <= LAT) check("mem_dado_esc", mem_dado_esc, ed);
      check("pronto_if", pronto_if, !win_d && k == LAT + 1);
      check("pronto_dados", pronto_dados, win_d && k == LAT + 1);
      if (k == LAT + 1) check("dado_lido", dado_lido, exp_lido);
      if (k == 1 && muda) begin
        if (win_d) begin
          end_dados = novo_end;
          dado_esc  = ~dado_esc;
          esc_dados = ~esc_dados;
        end else begin
          end_if = novo_end;
        end
      end
    end
    if (win_d) req_dados = 1'b0;
    else       req_if    = 1'b0;
    ult_dados = win_d;
    @(negedge clk);
    check_idle("idle");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ult_dados = 1'b0;
    exp_lido  = '0;
  endtask

  task automatic lat_run(input bit qual, input logic [7:0] ende, input int lat_esp);
    int obs;
    obs = 0;
    if (qual) begin b_req = 1'b1; b_end = ende; end
    else      begin a_req = 1'b1; a_end = ende; end
    for (int k = 1; k <= 40 && obs == 0; k++) begin
      @(negedge clk);
      if (qual ? b_pronto : a_pronto) begin
        obs = k;
        check(qual ? "lat15_dado" : "lat1_dado", qual ? b_lido : a_lido, {8'h5A, ende});
        check(qual ? "lat15_gnt" : "lat1_gnt", qual ? b_gnt_if : a_gnt_if, 1);
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check(qual ? "lat15_cycles" : "lat1_cycles", obs, lat_esp);
    @(negedge clk);
    check(qual ? "lat15_idle" : "lat1_idle", qual ? b_ocupado : a_ocupado, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_if = 1'b0; req_dados = 1'b0; esc_dados = 1'b0;
    end_if = '0; end_dados = '0; dado_esc = '0;
    a_req = 1'b0; b_req = 1'b0; a_end = '0; b_end = '0;
    ult_dados = 1'b0;
    exp_lido  = '0;
    for (int i = 0; i < 256; i++) begin
      semente[i] = 16'($urandom);
      ref_mem[i] = semente[i];
    end
    semente[8'h10] = 16'hABCD;
    ref_mem[8'h10] = 16'hABCD;
    carga = 1'b1;
    repeat (2) @(negedge clk);
    carga = 1'b0;

    // Reset state
    check_idle("reset");
    check("reset_mem_end", mem_end, 0);
    check("reset_mem_dado_esc", mem_dado_esc, 0);
    check("reset_lat_ocupado", {a_ocupado, b_ocupado}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch read of 0x10; fetch address changed to 0x99 mid-access must not leak
    req_if = 1'b1; end_if = 8'h10;
    txn(1'b1, 8'h99);

    // Data write of 0x1234 to 0x20; dado_lido keeps 0xABCD
    req_dados = 1'b1; esc_dados = 1'b1; end_dados = 8'h20; dado_esc = 16'h1234;
    txn(1'b0, 8'h00);

    // Contention right after reset: data first, then fetch, then alternation
    do_reset();
    req_if = 1'b1; end_if = 8'h20;
    req_dados = 1'b1; esc_dados = 1'b0; end_dados = 8'h10;
    txn(1'b0, 8'h00);
    txn(1'b0, 8'h00);
    req_if = 1'b1; end_if = 8'h30;
    req_dados = 1'b1; esc_dados = 1'b1; end_dados = 8'h30; dado_esc = 16'h5555;
    txn(1'b0, 8'h00);
    txn(1'b0, 8'h00);

    // Reset in the second ACESSO cycle abandons the access
    req_if = 1'b1; end_if = 8'h44;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_mem_en_before", mem_en, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_en", mem_en, 0);
    check("rst_mid_gnt", {gnt_if, gnt_dados}, 0);
    check("rst_mid_ocupado", ocupado, 0);
    check("rst_mid_pronto", {pronto_if, pronto_dados}, 0);
    check("rst_mid_dado_lido", dado_lido, 0);
    @(negedge clk);
    check("rst_mid_pronto_held", {pronto_if, pronto_dados}, 0);
    rst_n = 1'b1;
    ult_dados = 1'b0;
    exp_lido  = '0;
    txn(1'b0, 8'h00);

    // Randomized traffic on a small address window so reads hit earlier writes
    for (int n = 0; n < 60; n++) begin
      if (!req_if && $urandom_range(0, 1) == 1) begin
        req_if = 1'b1;
        end_if = 8'($urandom_range(0, 15));
      end
      if (!req_dados && $urandom_range(0, 1) == 1) begin
        req_dados = 1'b1;
        esc_dados = 1'($urandom_range(0, 1));
        end_dados = 8'($urandom_range(0, 15));
        dado_esc  = 16'($urandom);
      end
      if (!req_if && !req_dados) begin
        req_if = 1'b1;
        end_if = 8'($urandom_range(0, 15));
      end
      txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end
    for (int n = 0; n < 2; n++) begin
      if (req_if || req_dados) txn(1'b0, 8'h00);
    end

    // Latency extremes
    lat_run(1'b0, 8'h3C, 2);
    lat_run(1'b1, 8'hC3, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
